kuz_decrypt_core: RTL
=====================

Name: kuz_decrypt_core

Overview:
- Iterative Kuznechik (GOST R 34.12-2015) block decryptor. It is the inverse-direction companion of the encryption datapath in crypto.
- Reads the ten expanded round keys from the existing 16x128 key store. It drives that store's rd_addr and consumes its registered q, which has 1-cycle read latency.
- Turns one 128-bit ciphertext into plaintext in 155 cycles, using one R^-1 step per cycle to keep area small.

Parameters:
- KEY_BASE, 0: key-store address of K1; K_i lives at KEY_BASE+i-1, so K10 is at KEY_BASE+9.
- ADDR_W, 4: key-store address width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- keys_valid  in  1  high once key expansion has finished writing K1..K10.
- start  in  1  request; sampled only in IDLE.
- data_in  in  128  ciphertext; byte a15 = bits [127:120].
- key_q  in  128  key-store q; valid 1 cycle after rd_addr.
- rd_addr  out  ADDR_W  key-store read address.
- busy  out  1  high from FETCH through last SUB.
- ready  out  1  one-cycle pulse; plaintext is valid.
- data_out  out  128  plaintext; held until next accepted start.

Behaviour:
- Reset, synchronous, wins over everything:
  - state=IDLE; busy=0, ready=0, data_out=0, rd_addr=KEY_BASE, counters 0.
  - Reset asserted mid-operation aborts the block; no ready pulse follows.
- Algorithm:
  - s = C xor K10.
  - For i=9 down to 1: s = S^-1(L^-1(s)) xor K_i.
  - Plaintext = s.
  - L^-1 = R^-1 applied 16 times.
  - R^-1(b15..b0) = b14..b0 || l(b14,b13,..,b0,b15).
  - l(x15..x0) = 148x15+32x14+133x13+16x12+194x11+192x10+1x9+251x8+1x7+192x6+194x5+16x4+133x3+32x2+148x1+1x0.
  - l is evaluated in GF(2^8) mod x^8+x^7+x^6+x+1 (0x1C3).
- FSM IDLE -> FETCH -> WHITEN -> (LINV x16 -> SUB) x9 -> IDLE.
  - IDLE:
    - If start and keys_valid: latch data_in into s, set rd_addr=KEY_BASE+9, busy=1, go to FETCH. Call this edge t0.
    - start while !keys_valid is ignored.
  - FETCH: one wait cycle for key_q; at edge t1 the store registers K10.
  - WHITEN, edge t2:
    - s <= s xor key_q.
    - rd_addr <= KEY_BASE+8.
    - round <= 8; step <= 0.
  - LINV:
    - Each cycle: s <= R^-1(s), step++.
    - After step 15 (16 edges), go to SUB.
    - key_q is stable for the whole state because rd_addr is held.
  - SUB:
    - s <= invpi(s) bytewise xor key_q.
    - If round==0: data_out <= result, ready=1 for one cycle, busy=0, go to IDLE.
    - Else: round--, rd_addr--, step=0, go to LINV.
- Timing:
  - Final SUB occurs at edge t0+155. ready is high in the cycle after that edge, and busy falls in the same cycle.
  - Back-to-back operation: start may be accepted in the cycle that ready is high, since the FSM is already in IDLE. The next plaintext follows 155 cycles later.
- start while busy: ignored; no queuing.
- Changes to data_in after acceptance have no effect.
- Mid-operation keys_valid drop: ignored; the in-flight block completes with whatever the store returns.
- rd_addr arithmetic is modulo 2^ADDR_W. KEY_BASE+9 must be <= 2^ADDR_W-1; violating this is an elaboration error.

Decomposition:
- Package kuz_pkg, shared with the encryptor:
  - PI_INV[0:255] byte table, plus PI if it is not already there.
  - L_COEF[0:15].
  - GF_POLY = 8'hC3 (implicit x^8).
  - gf_mul function.
  - FSM state encoding.
- Sub-module kuz_linv_step: combinational R^-1 on 128 bits, using gf_mul and L_COEF.
- The S^-1 stage stays inline as 16 PI_INV lookups.

Test Plan:
- GOST A.1 vector:
  - Preload K1..K10 from the standard, including K1=8899aabbccddeeff0011223344556677, K2=fedcba98765432100123456789abcdef, K10=72e9dd7416bcf45b755dbaa88e4a4043.
  - Raise keys_valid; start with data_in=7f679d90bebc24305a468d42b9d4edcd.
  - Expect ready exactly 155 cycles after the accept edge, data_out=1122334455667700ffeeddccbbaa9988, and rd_addr sequence 9,8,...,0.
- Keys-not-valid: keys_valid=0, pulse start -> busy stays 0 and no ready for 200 cycles.
- start while busy:
  - Second start at cycle 50 with a different data_in -> ignored.
  - The same single ready arrives at 155 with the A.1 plaintext.
- Reset mid-op: assert rst at cycle 80 -> next cycle busy=0, ready=0, data_out=0, rd_addr=KEY_BASE; no ready ever appears.
- Back-to-back: start held high continuously -> ready pulses every 156 cycles, each with the correct plaintext.
- Randomized roundtrip:
  - 200 random keys and plaintexts through the bench encryption model and the existing key expansion.
  - Decrypt each and compare with the original plaintext; also run with KEY_BASE=6.

Source files
------------

// File: rtl/kuz_pkg.sv
// kuz_pkg: shared Kuznechik constants and helpers.
// Used by both the encryption and decryption datapaths.
package kuz_pkg;

  typedef logic [0:255][7:0] sbox_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WHITEN,
    ST_LINV,
    ST_SUB
  } kuz_state_e;

  localparam logic [7:0] GF_POLY = 8'hC3;

  localparam logic [0:15][7:0] L_COEF = {
    8'd1,   8'd148, 8'd32,  8'd133,
    8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194,
    8'd16,  8'd133, 8'd32,  8'd148
  };

  localparam sbox_t PI = {
    64'hFCEEDD11CF6E3116, 64'hFBC4FADA23C5044D,
    64'hE977F0DB932E99BA, 64'h1736F1BB14CD5FC1,
    64'hF918655AE25CEF21, 64'h811C3C428B018E4F,
    64'h058402AEE36A8FA0, 64'h060BED987FD4D31F,
    64'hEB342C51EAC848AB, 64'hF22A68A2FD3ACECC,
    64'hB5700E56080C7612, 64'hBF7213479CB75D87,
    64'h15A19629107B9AC7, 64'hF391786F9D9EB2B1,
    64'h3275193DFF358A7E, 64'h6D54C680C3BD0D57,
    64'hDFF524A93EA843C9, 64'hD779D6F67C22B903,
    64'hE00FECDE7A94B0BC, 64'hDCE828504E330A4A,
    64'hA79760731E006244, 64'h1AB83882649F2641,
    64'hAD454692275E552F, 64'h8CA3A57D69D5953B,
    64'h0758B34086AC1DF7, 64'h30376BE488D9E789,
    64'hE11B83494C3FF8FE, 64'h8D53AA90CAD88561,
    64'h207167A42D2B095B, 64'hCB9B25D0BEE56C52,
    64'h59A674D2E6F4B4C0, 64'hD166AFC2394B63B6
  };

  function automatic sbox_t sbox_inv(input sbox_t p);
    sbox_t r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[p[i]] = 8'(i);
    return r;
  endfunction

  localparam sbox_t PI_INV = sbox_inv(PI);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i])
        p = p ^ x;
      x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/kuz_decrypt_core_linv.sv
// kuz_linv_step: one combinational R^-1 step.
// Shifts bytes up and rebuilds b0 from the linear map l.
module kuz_linv_step
  import kuz_pkg::*;
(
  input  logic [127:0] d,
  output logic [127:0] q
);

  logic [7:0] acc;

  // b15 carries the unit-weight term; b14..b0 feed x15..x1
  always_comb begin
    acc = d[127:120];
    for (int j = 1; j < 16; j++)
      acc = acc ^ gf_mul(L_COEF[j], d[8*j-8 +: 8]);
  end

  assign q = {d[119:0], acc};

endmodule

// File: rtl/kuz_decrypt_core.sv
// kuz_decrypt_core: iterative Kuznechik block decryptor.
// One R^-1 per cycle; keys read from an external 1-cycle store.
module kuz_decrypt_core
  import kuz_pkg::*;
#(
  parameter int KEY_BASE = 0,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keys_valid,
  input  logic              start,
  input  logic [127:0]      data_in,
  input  logic [127:0]      key_q,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              ready,
  output logic [127:0]      data_out
);

  localparam logic [ADDR_W-1:0] A_K1  =
    ADDR_W'(KEY_BASE);
  localparam logic [ADDR_W-1:0] A_K9  =
    ADDR_W'(KEY_BASE + 8);
  localparam logic [ADDR_W-1:0] A_K10 =
    ADDR_W'(KEY_BASE + 9);

  if (KEY_BASE < 0 ||
      KEY_BASE + 9 > (1 << ADDR_W) - 1) begin : g_bad_base
    $error("KEY_BASE+9 does not fit the key store");
  end

  kuz_state_e   state;
  kuz_state_e   state_nxt;
  logic [127:0] s;
  logic [127:0] s_nxt;
  logic [127:0] linv_out;
  logic [127:0] sub_out;
  logic [3:0]   step;
  logic [3:0]   round;
  logic         accept;
  logic         last_sub;

  assign accept   = (state == ST_IDLE) &&
                    start && keys_valid;
  assign last_sub = (state == ST_SUB) &&
                    (round == 4'd0);
  assign busy     = (state != ST_IDLE);

  kuz_linv_step u_linv (
    .d (s),
    .q (linv_out)
  );

  // inverse S-box per byte, then add the round key
  always_comb begin
    sub_out = '0;
    for (int b = 0; b < 16; b++)
      sub_out[8*b +: 8] =
        PI_INV[s[8*b +: 8]] ^ key_q[8*b +: 8];
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next-state: whiten, then 9 x (16 R^-1 + sub)
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_WHITEN;
      ST_WHITEN: state_nxt = ST_LINV;
      ST_LINV:   if (step == 4'd15) state_nxt = ST_SUB;
      ST_SUB:    state_nxt = (round == 4'd0) ?
                             ST_IDLE : ST_LINV;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // block state update for the current phase
  always_comb begin
    s_nxt = s;
    unique case (1'b1)
      accept:              s_nxt = data_in;
      state == ST_WHITEN:  s_nxt = s ^ key_q;
      state == ST_LINV:    s_nxt = linv_out;
      state == ST_SUB:     s_nxt = sub_out;
      default:             s_nxt = s;
    endcase
  end

  // datapath, key addressing and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '0;
      step     <= '0;
      round    <= '0;
      rd_addr  <= A_K1;
      ready    <= 1'b0;
      data_out <= '0;
    end else begin
      s     <= s_nxt;
      ready <= last_sub;
      if (last_sub)
        data_out <= sub_out;
      if (accept)
        rd_addr <= A_K10;
      if (state == ST_WHITEN) begin
        rd_addr <= A_K9;
        round   <= 4'd8;
        step    <= '0;
      end
      if (state == ST_LINV)
        step <= step + 4'd1;
      if (state == ST_SUB && round != 4'd0) begin
        round   <= round - 4'd1;
        rd_addr <= rd_addr - ADDR_W'(1);
        step    <= '0;
      end
    end
  end

endmodule
